// File: rtl/reg_file_dump_pkg.sv
// Shared constants for the register-file dump engine and the register file it reads.
package reg_file_dump_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } dump_state_t;

endpackage

// File: rtl/reg_file_dump_ostage.sv
// Single-entry valid/ready holding register for dump beats.
// A beat is captured whenever the stage is empty or its current beat is being taken.
module reg_file_dump_ostage
    import reg_file_dump_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_load,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last
);

    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    assign o_load = i_load_en && (!r_valid || i_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (o_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/reg_file_dump.sv
// Debug read-out engine: walks a register-file address range through one read
// port and streams (address, data) beats on a valid/ready channel.
module reg_file_dump
    import reg_file_dump_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_first_addr,
    input  logic [ADDR_WIDTH-1:0] i_last_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_range_err,
    output logic [ADDR_WIDTH-1:0] o_rf_raddr,
    input  logic [DATA_WIDTH-1:0] i_rf_rdata,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [ADDR_WIDTH-1:0] o_out_addr,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_last
);

    dump_state_t           r_state;
    dump_state_t           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] r_last;
    logic [ADDR_WIDTH-1:0] w_last_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  w_load_en;
    logic                  w_load;
    logic                  w_at_last;
    logic                  w_drain_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_last  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign w_at_last    = (r_ptr == r_last);
    assign w_drain_done = o_out_valid && i_out_ready && o_out_last;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_last_nxt  = r_last;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_first_addr <= i_last_addr) begin
                        w_ptr_nxt   = i_first_addr;
                        w_last_nxt  = i_last_addr;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = ST_RUN;
                    end else begin
                        // Bad range passes through DRAIN so done lands two cycles after start.
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_RUN: begin
                if (w_load) begin
                    if (w_at_last) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (r_err || w_drain_done) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_err_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_load_en   = (r_state == ST_RUN);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_FIN);
    assign o_range_err = o_done && r_err;
    assign o_rf_raddr  = w_load_en ? r_ptr : '0;

    reg_file_dump_ostage #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ostage (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load_en (w_load_en),
        .i_addr    (r_ptr),
        .i_data    (i_rf_rdata),
        .i_last    (w_at_last),
        .i_ready   (i_out_ready),
        .o_load    (w_load),
        .o_valid   (o_out_valid),
        .o_addr    (o_out_addr),
        .o_data    (o_out_data),
        .o_last    (o_out_last)
    );

endmodule
